count_sequencer: RTL and testbench

//   Command-driven controller for the 4-bit up/down counter datapath (Load/Count_en/Up/Count_in).

---
 rtl/count_sequencer_pkg.sv | 23 ++
 rtl/count_sequencer_if.sv | 30 +++
 rtl/count_sequencer_tick_prescaler.sv | 35 +++
 rtl/count_sequencer.sv | 166 ++++++++++++++++
 tb/tb_count_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/count_sequencer_pkg.sv
// Shared definitions for the count_sequencer controller: command opcodes,
// FSM state encoding and the default step rate for the 10 MHz board clock.
package count_sequencer_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_LOAD     = 2'b00;
    localparam op_t OP_RUN_UP   = 2'b01;
    localparam op_t OP_RUN_DOWN = 2'b10;
    localparam op_t OP_NOP      = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // 10 MHz board clock -> one counter step per second.
    localparam int unsigned TICK_DIV_DEFAULT = 32'd10_000_000;
    localparam int unsigned DIV_W_DEFAULT    = 32'd24;

endpackage

// File: rtl/count_sequencer_if.sv
// Command channel between the host/front-panel logic and count_sequencer.
//   Cmd_valid  host -> ctrl  command present
//   Cmd_ready  ctrl -> host  controller can accept a command
//   Cmd_op     host -> ctrl  LOAD / RUN_UP / RUN_DOWN / NOP
//   Cmd_value  host -> ctrl  load value or step count
interface count_sequencer_if #(
    parameter int CNT_W = 4
) ();
    import count_sequencer_pkg::*;

    logic             Cmd_valid;
    logic             Cmd_ready;
    op_t              Cmd_op;
    logic [CNT_W-1:0] Cmd_value;

    modport master (
        output Cmd_valid,
        output Cmd_op,
        output Cmd_value,
        input  Cmd_ready
    );

    modport slave (
        input  Cmd_valid,
        input  Cmd_op,
        input  Cmd_value,
        output Cmd_ready
    );

endinterface

// File: rtl/count_sequencer_tick_prescaler.sv
// Modulo-TICK_DIV prescaler that paces counter steps inside the Clk domain.
//   Clk     in   system clock, rising edge
//   nReset  in   asynchronous active-low reset
//   clr     in   synchronous clear; holds the count at zero and masks tick
//   tick    out  high for one cycle whenever the count sits at TICK_DIV-1
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 32'd10_000_000,
    parameter int unsigned DIV_W    = 32'd24
) (
    input  logic Clk,
    input  logic nReset,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST_CNT = DIV_W'(TICK_DIV - 32'd1);

    logic [DIV_W-1:0] cnt_r;

    // Wrapping prescale counter, parked at zero while cleared.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST_CNT) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign tick = (cnt_r == LAST_CNT) && !clr;

endmodule

// File: rtl/count_sequencer.sv
// Command-driven controller for a CNT_W-bit up/down counter datapath.
// Accepts one command at a time (LOAD value, RUN_UP/RUN_DOWN N steps, NOP)
// and paces RUN steps with an internal prescaler; all logic runs on Clk.
//   Clk, nReset  clock and asynchronous active-low reset
//   cmd          command channel (slave side, Cmd_ready high only in IDLE)
//   Abort        level; ends a RUN early
//   Count_val    counter output fed back for saturation checks
//   Load, Count_en, Up, Count_in   counter controls
//   Busy         command in progress
//   Done         one-cycle pulse closing every accepted command
//   Limit        sticky saturation flag, cleared on the next accept
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
    parameter int unsigned DIV_W    = DIV_W_DEFAULT,
    parameter int          CNT_W    = 4,
    parameter bit          WRAP     = 1'b1
) (
    input  logic             Clk,
    input  logic             nReset,
    count_sequencer_if.slave cmd,
    input  logic             Abort,
    input  logic [CNT_W-1:0] Count_val,
    output logic             Load,
    output logic             Count_en,
    output logic             Up,
    output logic [CNT_W-1:0] Count_in,
    output logic             Busy,
    output logic             Done,
    output logic             Limit
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] STEP_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [CNT_W-1:0] steps_r;
    logic [CNT_W-1:0] count_in_r;
    logic             up_r;
    logic             load_r;
    logic             count_en_r;
    logic             busy_r;
    logic             done_r;
    logic             limit_r;
    logic             ready_r;

    logic             accept_s;
    logic             tick_s;
    logic             clr_s;
    logic             at_bound_s;

    assign accept_s = cmd.Cmd_valid && ready_r;
    // Prescaler only runs inside RUN, so it restarts from zero on every entry.
    assign clr_s    = (state_r != S_RUN);
    // Saturation only matters when the counter is not allowed to wrap.
    assign at_bound_s = !WRAP && (up_r ? (Count_val == CNT_MAX) : (Count_val == CNT_ZERO));

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_tick_prescaler (
        .Clk    (Clk),
        .nReset (nReset),
        .clr    (clr_s),
        .tick   (tick_s)
    );

    // Command FSM with registered counter controls and status outputs.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_r    <= S_IDLE;
            steps_r    <= CNT_ZERO;
            count_in_r <= CNT_ZERO;
            up_r       <= 1'b0;
            load_r     <= 1'b0;
            count_en_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            limit_r    <= 1'b0;
            ready_r    <= 1'b1;
        end else begin
            // Single-cycle strobes drop unless re-asserted below.
            load_r     <= 1'b0;
            count_en_r <= 1'b0;
            done_r     <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        busy_r  <= 1'b1;
                        ready_r <= 1'b0;
                        limit_r <= 1'b0;
                        case (cmd.Cmd_op)
                            OP_LOAD: begin
                                state_r    <= S_LOAD;
                                load_r     <= 1'b1;
                                count_in_r <= cmd.Cmd_value;
                            end
                            OP_RUN_UP, OP_RUN_DOWN: begin
                                state_r <= S_RUN;
                                steps_r <= cmd.Cmd_value;
                                up_r    <= (cmd.Cmd_op == OP_RUN_UP);
                            end
                            OP_NOP: begin
                                state_r <= S_DONE;
                                done_r  <= 1'b1;
                            end
                            default: begin
                                state_r <= S_DONE;
                                done_r  <= 1'b1;
                            end
                        endcase
                    end
                end
                S_LOAD: begin
                    state_r <= S_DONE;
                    done_r  <= 1'b1;
                end
                S_RUN: begin
                    // Abort outranks a coincident tick: no step is issued.
                    if (Abort) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                    end else if (steps_r == CNT_ZERO) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                    end else if (tick_s) begin
                        if (at_bound_s) begin
                            limit_r <= 1'b1;
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            count_en_r <= 1'b1;
                            steps_r    <= steps_r - STEP_ONE;
                            if (steps_r == STEP_ONE) begin
                                state_r <= S_DONE;
                                done_r  <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign cmd.Cmd_ready = ready_r;
    assign Load          = load_r;
    assign Count_en      = count_en_r;
    assign Up            = up_r;
    assign Count_in      = count_in_r;
    assign Busy          = busy_r;
    assign Done          = done_r;
    assign Limit         = limit_r;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: one wrapping and one saturating instance, each
// with a counter model on its outputs. Commands come from a vector table;
// expectations go to a scoreboard queue and are checked when Done appears.
module tb_count_sequencer;
    import count_sequencer_pkg::*;

    localparam int TD = 4;
    localparam int NV = 15;
    localparam logic [10:0] RESET_PACK = 11'h001;

    logic Clk = 1'b0;
    logic nReset;
    always #5 Clk = ~Clk;

    logic       sel;
    logic       cmd_valid;
    op_t        cmd_op;
    logic [3:0] cmd_value;
    logic       abort;

    count_sequencer_if #(.CNT_W(4)) if_w ();
    count_sequencer_if #(.CNT_W(4)) if_s ();

    assign if_w.Cmd_valid = cmd_valid & ~sel;
    assign if_w.Cmd_op    = cmd_op;
    assign if_w.Cmd_value = cmd_value;
    assign if_s.Cmd_valid = cmd_valid & sel;
    assign if_s.Cmd_op    = cmd_op;
    assign if_s.Cmd_value = cmd_value;

    logic       abort_w, abort_s;
    assign abort_w = abort & ~sel;
    assign abort_s = abort & sel;

    logic       w_load, w_cen, w_up, w_busy, w_done, w_limit;
    logic [3:0] w_cin, cnt_w;
    logic       s_load, s_cen, s_up, s_busy, s_done, s_limit;
    logic [3:0] s_cin, cnt_s;

    count_sequencer #(.TICK_DIV(TD), .DIV_W(8), .CNT_W(4), .WRAP(1'b1)) u_dut_wrap (
        .Clk(Clk), .nReset(nReset), .cmd(if_w.slave), .Abort(abort_w), .Count_val(cnt_w),
        .Load(w_load), .Count_en(w_cen), .Up(w_up), .Count_in(w_cin),
        .Busy(w_busy), .Done(w_done), .Limit(w_limit));

    count_sequencer #(.TICK_DIV(TD), .DIV_W(8), .CNT_W(4), .WRAP(1'b0)) u_dut_sat (
        .Clk(Clk), .nReset(nReset), .cmd(if_s.slave), .Abort(abort_s), .Count_val(cnt_s),
        .Load(s_load), .Count_en(s_cen), .Up(s_up), .Count_in(s_cin),
        .Busy(s_busy), .Done(s_done), .Limit(s_limit));

    // Counter datapath model driven by the wrapping controller.
    always @(posedge Clk or negedge nReset) begin
        if (!nReset)     cnt_w <= 4'h0;
        else if (w_load) cnt_w <= w_cin;
        else if (w_cen)  cnt_w <= w_up ? cnt_w + 4'h1 : cnt_w - 4'h1;
    end

    // Counter datapath model driven by the saturating controller.
    always @(posedge Clk or negedge nReset) begin
        if (!nReset)     cnt_s <= 4'h0;
        else if (s_load) cnt_s <= s_cin;
        else if (s_cen)  cnt_s <= s_up ? cnt_s + 4'h1 : cnt_s - 4'h1;
    end

    logic [10:0] w_pack, s_pack;
    assign w_pack = {w_load, w_cen, w_up, w_cin, w_busy, w_done, w_limit, if_w.Cmd_ready};
    assign s_pack = {s_load, s_cen, s_up, s_cin, s_busy, s_done, s_limit, if_s.Cmd_ready};

    logic       obs_load, obs_cen, obs_up, obs_busy, obs_done, obs_limit, obs_ready;
    logic [3:0] obs_cnt;
    assign obs_load  = sel ? s_load  : w_load;
    assign obs_cen   = sel ? s_cen   : w_cen;
    assign obs_up    = sel ? s_up    : w_up;
    assign obs_busy  = sel ? s_busy  : w_busy;
    assign obs_done  = sel ? s_done  : w_done;
    assign obs_limit = sel ? s_limit : w_limit;
    assign obs_ready = sel ? if_s.Cmd_ready : if_w.Cmd_ready;
    assign obs_cnt   = sel ? cnt_s   : cnt_w;

    typedef struct packed {
        logic       sel;
        logic [1:0] op;
        logic [3:0] val;
        int         abort_k;
        int         exp_pulses;
        int         exp_loads;
        logic [3:0] exp_cnt;
        logic       exp_limit;
        logic       exp_up;
        int         exp_lat;
    } vec_t;

    vec_t tbl [NV];
    vec_t sb_q [$];
    vec_t run_v;
    vec_t cur_v;

    int n_vec, n_bad;
    int cyc, acc_cyc, pulses, loads, done_lat;
    bit overlap, timing_bad, dir_bad, pending, complete;

    function automatic vec_t mk(input logic s, input logic [1:0] op, input logic [3:0] val,
                                input int ak, input int ep, input int el, input logic [3:0] ec,
                                input logic elim, input logic eup, input int lat);
        vec_t v;
        v.sel = s; v.op = op; v.val = val; v.abort_k = ak;
        v.exp_pulses = ep; v.exp_loads = el; v.exp_cnt = ec;
        v.exp_limit = elim; v.exp_up = eup; v.exp_lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        if (obs_load === 1'b1 && obs_cen === 1'b1) overlap = 1'b1;
        if (obs_load === 1'b1) loads++;
        if (obs_cen === 1'b1) begin
            pulses++;
            if (cyc - acc_cyc != TD * pulses) timing_bad = 1'b1;
            if (obs_up !== run_v.exp_up) dir_bad = 1'b1;
        end
        if (pending) begin
            pending = 1'b0;
            chk("pulses",      pulses,     cur_v.exp_pulses);
            chk("loads",       loads,      cur_v.exp_loads);
            chk("count_val",   {28'd0, obs_cnt}, {28'd0, cur_v.exp_cnt});
            chk("limit",       {31'd0, obs_limit}, {31'd0, cur_v.exp_limit});
            chk("done_lat",    done_lat,   cur_v.exp_lat);
            chk("load_cen_overlap", {31'd0, overlap}, 32'd0);
            chk("pulse_timing", {31'd0, timing_bad}, 32'd0);
            chk("up_stable",   {31'd0, dir_bad}, 32'd0);
            chk("done_width",  {31'd0, obs_done}, 32'd0);
            chk("busy_after",  {31'd0, obs_busy}, 32'd0);
            chk("ready_after", {31'd0, obs_ready}, 32'd1);
            complete = 1'b1;
        end
        if (obs_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", {31'd0, obs_done}, 32'd0);
            end else begin
                cur_v    = sb_q.pop_front();
                pending  = 1'b1;
                done_lat = cyc - acc_cyc;
            end
        end
    endtask

    task automatic step();
        @(negedge Clk);
        monitor();
        @(posedge Clk);
        cyc++;
        #1;
    endtask

    task automatic mark_accept(input vec_t v);
        acc_cyc = cyc; run_v = v;
        pulses = 0; loads = 0;
        overlap = 1'b0; timing_bad = 1'b0; dir_bad = 1'b0; complete = 1'b0;
    endtask

    task automatic send(input vec_t v, input bit score);
        int b;
        if (score) sb_q.push_back(v);
        sel = v.sel; cmd_op = v.op; cmd_value = v.val; cmd_valid = 1'b1;
        b = 0;
        while (obs_ready !== 1'b1 && b < 200) begin step(); b++; end
        chk("ready_wait", {31'd0, (b < 200)}, 32'd1);
        step();
        mark_accept(v);
        cmd_valid = 1'b0;
        chk("ready_drop", {31'd0, obs_ready}, 32'd0);
        chk("busy_rise",  {31'd0, obs_busy}, 32'd1);
        if (v.abort_k > 0) begin
            repeat (TD * v.abort_k - 1) step();
            abort = 1'b1;
            step();
            abort = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int b = 0;
        while (!complete && b < 400) begin step(); b++; end
        chk("done_wait", {31'd0, (b < 400)}, 32'd1);
    endtask

    initial begin
        sel = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_value = 4'h0; abort = 1'b0;
        nReset = 1'b0;
        n_vec = 0; n_bad = 0; cyc = 0; acc_cyc = 0; pulses = 0; loads = 0; done_lat = 0;
        overlap = 1'b0; timing_bad = 1'b0; dir_bad = 1'b0; pending = 1'b0; complete = 1'b0;

        tbl[0]  = mk(1'b0, OP_LOAD,     4'hA,  0, 0, 1, 4'hA, 1'b0, 1'b0, 1);
        tbl[1]  = mk(1'b0, OP_LOAD,     4'h3,  0, 0, 1, 4'h3, 1'b0, 1'b0, 1);
        tbl[2]  = mk(1'b0, OP_RUN_UP,   4'd5,  0, 5, 0, 4'h8, 1'b0, 1'b1, 20);
        tbl[3]  = mk(1'b0, OP_LOAD,     4'h1,  0, 0, 1, 4'h1, 1'b0, 1'b0, 1);
        tbl[4]  = mk(1'b0, OP_RUN_DOWN, 4'd3,  0, 3, 0, 4'hE, 1'b0, 1'b0, 12);
        tbl[5]  = mk(1'b1, OP_LOAD,     4'h1,  0, 0, 1, 4'h1, 1'b0, 1'b0, 1);
        tbl[6]  = mk(1'b1, OP_RUN_DOWN, 4'd3,  0, 1, 0, 4'h0, 1'b1, 1'b0, 8);
        tbl[7]  = mk(1'b1, OP_LOAD,     4'hE,  0, 0, 1, 4'hE, 1'b0, 1'b0, 1);
        tbl[8]  = mk(1'b1, OP_RUN_UP,   4'd3,  0, 1, 0, 4'hF, 1'b1, 1'b1, 8);
        tbl[9]  = mk(1'b0, OP_RUN_UP,   4'd0,  0, 0, 0, 4'hE, 1'b0, 1'b1, 1);
        tbl[10] = mk(1'b0, OP_NOP,      4'd0,  0, 0, 0, 4'hE, 1'b0, 1'b0, 0);
        tbl[11] = mk(1'b0, OP_RUN_UP,   4'd10, 3, 2, 0, 4'h0, 1'b0, 1'b1, 12);
        tbl[12] = mk(1'b0, OP_LOAD,     4'hF,  0, 0, 1, 4'hF, 1'b0, 1'b0, 1);
        tbl[13] = mk(1'b0, OP_RUN_UP,   4'd2,  0, 2, 0, 4'h1, 1'b0, 1'b1, 8);
        tbl[14] = mk(1'b1, OP_NOP,      4'd0,  0, 0, 0, 4'hF, 1'b0, 1'b0, 0);

        repeat (2) @(posedge Clk);
        #1;
        chk("reset_wrap", {21'd0, w_pack}, {21'd0, RESET_PACK});
        chk("reset_sat",  {21'd0, s_pack}, {21'd0, RESET_PACK});
        nReset = 1'b1;
        step();
        step();

        // Reset one cycle after the second step of a RUN: no Done may follow.
        send(mk(1'b0, OP_RUN_UP, 4'd5, 0, 0, 0, 4'h0, 1'b0, 1'b1, 0), 1'b0);
        repeat (TD * 2) step();
        chk("second_cen", {31'd0, w_cen}, 32'd1);
        step();
        nReset = 1'b0;
        #1;
        chk("midrun_reset", {21'd0, w_pack}, {21'd0, RESET_PACK});
        step();
        nReset = 1'b1;
        repeat (TD * 3) step();
        chk("post_reset_idle", {21'd0, w_pack}, {21'd0, RESET_PACK});

        for (int i = 0; i < NV; i++) begin
            send(tbl[i], 1'b1);
            wait_idle();
        end

        // Second command presented while the first is still running.
        send(mk(1'b0, OP_RUN_UP, 4'd1, 0, 1, 0, 4'h2, 1'b0, 1'b1, 4), 1'b1);
        send(mk(1'b0, OP_LOAD,   4'h7, 0, 0, 1, 4'h7, 1'b0, 1'b0, 1), 1'b1);
        wait_idle();
        step();
        chk("scoreboard_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
